// File: rtl/uart_pkt_decoder_pkg.sv
// rtl/uart_pkt_decoder_pkg.sv - shared types and constants for the UART packet decoder
package uart_pkt_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

  // A length byte is unusable if it is zero or larger than the payload buffer.
  function automatic logic len_bad(input logic [7:0] len_byte, input int max_len);
    return (len_byte == 8'd0) || (int'(len_byte) > max_len);
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// rtl/uart_pkt_buf.sv - payload register file, one write port and one async read port
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_data
);

  // Contents are never reset; the FSM only reads entries it wrote for the current packet.
  logic [7:0] mem_q [DEPTH];

  // Write the addressed entry on a write strobe.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_idx == AW'(i))) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  // Async read; indices past the buffer return zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == AW'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/uart_pkt_decoder.sv
// rtl/uart_pkt_decoder.sv - frames UART bytes into checksummed packets and streams the payload
module uart_pkt_decoder
  import uart_pkt_decoder_pkg::*;
#(
  parameter logic [7:0] SOF     = DEFAULT_SOF,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_ok,
  output logic       err_csum,
  output logic       err_len,
  output logic       err_tmo,
  output logic       err_ovr
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] ONE_L    = LW'(1);
  localparam logic [TW-1:0] ONE_T    = TW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] rd_q, rd_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          err_csum_q, err_csum_d;
  logic          err_len_q, err_len_d;
  logic          err_tmo_q, err_tmo_d;
  logic          err_ovr_q, err_ovr_d;

  logic          wr_en;
  logic [LW-1:0] rd_idx;
  logic [7:0]    rd_data;
  logic          in_frame;

  // While checking the checksum the read port presents entry 0; while draining it
  // looks one entry ahead so the next byte is ready to register on a handshake.
  assign rd_idx   = (state_q == ST_DRAIN) ? (rd_q + ONE_L) : '0;
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (in_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    csum_d      = csum_q;
    tmo_d       = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pkt_ok_d    = 1'b0;
    err_csum_d  = 1'b0;
    err_len_d   = 1'b0;
    err_tmo_d   = 1'b0;
    err_ovr_d   = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && (in_data == SOF)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (in_valid) begin
          if (len_bad(in_data, MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            len_d   = in_data[LW-1:0];
            csum_d  = in_data;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          wr_en  = 1'b1;
          csum_d = csum_q ^ in_data;
          idx_d  = idx_q + ONE_L;
          if (idx_q == (len_q - ONE_L)) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (in_valid) begin
          if (in_data == csum_q) begin
            state_d     = ST_DRAIN;
            pkt_ok_d    = 1'b1;
            rd_d        = '0;
            out_valid_d = 1'b1;
            out_data_d  = rd_data;
            out_last_d  = (len_q == ONE_L);
          end else begin
            err_csum_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        err_ovr_d = in_valid;
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d     = ST_IDLE;
            rd_d        = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            rd_d       = rd_q + ONE_L;
            out_data_d = rd_data;
            out_last_d = ((rd_q + ONE_L) == (len_q - ONE_L));
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Inter-byte watchdog: only runs between bytes of a frame.
    if (in_frame && !in_valid) begin
      tmo_d = tmo_q + ONE_T;
      if (tmo_q == TMO_LAST) begin
        err_tmo_d = 1'b1;
        tmo_d     = '0;
        state_d   = ST_IDLE;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      err_csum_q  <= 1'b0;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pkt_ok_q    <= pkt_ok_d;
      err_csum_q  <= err_csum_d;
      err_len_q   <= err_len_d;
      err_tmo_q   <= err_tmo_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign pkt_ok    = pkt_ok_q;
  assign err_csum  = err_csum_q;
  assign err_len   = err_len_q;
  assign err_tmo   = err_tmo_q;
  assign err_ovr   = err_ovr_q;

endmodule
